// File: rtl/c_burst_scheduler_pkg.sv
// Shared types and constants for the blockC burst scheduler.
package c_burst_scheduler_pkg;

    localparam int C_ANOTHER_SIZE = 10;
    localparam int D_SIZE         = 3;

    localparam logic [3:0] C_ST_IDLE  = 4'h0;
    localparam logic [3:0] C_ST_BURST = 4'h1;
    localparam logic [3:0] C_ST_ABORT = 4'h2;

    typedef logic [D_SIZE-1:0] dT;

    typedef struct packed {
        dT d;
    } dSt;

    typedef enum logic [3:0] {
        C_IDLE  = C_ST_IDLE,
        C_BURST = C_ST_BURST,
        C_ABORT = C_ST_ABORT
    } cStateT;

    // Beat payload is the seed offset by the beat number, wrapping silently.
    function automatic dT beat_payload(input dT seed, input logic [3:0] beat);
        return seed + beat[D_SIZE-1:0];
    endfunction

endpackage

// File: rtl/c_burst_scheduler_arb.sv
// Combinational round-robin winner select: rotate requests so rr_ptr+1 is
// bit 0, pick the lowest set bit, then rotate the index back.
module c_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    logic [IW:0]        start;
    logic [NUM_REQ-1:0] rot;
    logic [IW-1:0]      rot_idx;
    logic               found;
    logic [IW:0]        sum;

    always_comb begin
        logic [IW:0] idx;
        start = (rr_ptr == IW'(NUM_REQ - 1)) ? '0 : ({1'b0, rr_ptr} + 1'b1);
        rot   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (IW + 1)'(i) + start;
            if (idx >= (IW + 1)'(NUM_REQ)) begin
                idx = idx - (IW + 1)'(NUM_REQ);
            end
            rot[i] = req[idx[IW-1:0]];
        end
    end

    always_comb begin
        found   = 1'b0;
        rot_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rot[i] && !found) begin
                found   = 1'b1;
                rot_idx = IW'(i);
            end
        end
        sum = {1'b0, rot_idx} + start;
        if (sum >= (IW + 1)'(NUM_REQ)) begin
            sum = sum - (IW + 1)'(NUM_REQ);
        end
        grant_idx = sum[IW-1:0];
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant[gi] = found && (grant_idx == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/c_burst_scheduler.sv
// Round-robin burst scheduler feeding blockC's d-datapath.
// Optional stall timeout/abort enabled by defining C_BURST_SCHED_TIMEOUT_EN.
module c_burst_scheduler
    import c_burst_scheduler_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = C_ANOTHER_SIZE,
    parameter int TIMEOUT   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*D_SIZE-1:0]   req_d,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output dSt                          out_d,
    output logic [3:0]                  out_idx,
    output logic                        out_last,
    output logic [$clog2(NUM_REQ)-1:0]  out_src,
    output cStateT                      c_state,
    output logic                        abort
);

    localparam int IW = $clog2(NUM_REQ);

    cStateT       state_q,     state_d;
    logic [IW-1:0] rr_ptr_q,   rr_ptr_d;
    logic [3:0]   beat_q,      beat_d;
    dT            seed_q,      seed_d;
    logic         out_valid_q, out_valid_d;
    logic         out_last_q,  out_last_d;
    dSt           out_d_q,     out_d_d;
    logic [IW-1:0] out_src_q,  out_src_d;
    logic [NUM_REQ-1:0] req_ready_c;

`ifdef C_BURST_SCHED_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall_q, stall_d;
    logic          abort_q, abort_d;
`endif

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    dT                  seeds [NUM_REQ];

    c_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_seed
            assign seeds[gi] = req_d[gi*D_SIZE +: D_SIZE];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        beat_d      = beat_q;
        seed_d      = seed_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_d_d     = out_d_q;
        out_src_d   = out_src_q;
        req_ready_c = '0;
`ifdef C_BURST_SCHED_TIMEOUT_EN
        stall_d     = stall_q;
        abort_d     = 1'b0;
`endif
        case (state_q)
            C_IDLE: begin
                if (|req_valid) begin
                    req_ready_c = arb_grant;
                    seed_d      = seeds[arb_idx];
                    out_src_d   = arb_idx;
                    rr_ptr_d    = arb_idx;
                    beat_d      = '0;
                    out_valid_d = 1'b1;
                    out_d_d.d   = seeds[arb_idx];
                    out_last_d  = (BURST_LEN == 1);
                    state_d     = C_BURST;
`ifdef C_BURST_SCHED_TIMEOUT_EN
                    stall_d     = '0;
`endif
                end
            end
            C_BURST: begin
                if (out_ready) begin
`ifdef C_BURST_SCHED_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (out_last_q) begin
                        state_d     = C_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        beat_d      = '0;
                        out_d_d     = '0;
                    end else begin
                        beat_d     = beat_q + 4'd1;
                        out_d_d.d  = beat_payload(seed_q, beat_d);
                        out_last_d = (beat_d == 4'(BURST_LEN - 1));
                    end
                end
`ifdef C_BURST_SCHED_TIMEOUT_EN
                // Reaching TIMEOUT stalled cycles drops the burst; rr_ptr stays on the victim.
                else if (stall_q == SW'(TIMEOUT - 1)) begin
                    state_d     = C_ABORT;
                    abort_d     = 1'b1;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    beat_d      = '0;
                    out_d_d     = '0;
                    stall_d     = '0;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
`ifdef C_BURST_SCHED_TIMEOUT_EN
            C_ABORT: begin
                state_d = C_IDLE;
            end
`endif
            default: begin
                state_d     = C_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                beat_d      = '0;
                out_d_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= C_IDLE;
            rr_ptr_q    <= IW'(NUM_REQ - 1);
            beat_q      <= '0;
            seed_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_d_q     <= '0;
            out_src_q   <= '0;
`ifdef C_BURST_SCHED_TIMEOUT_EN
            stall_q     <= '0;
            abort_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_q      <= beat_d;
            seed_q      <= seed_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_d_q     <= out_d_d;
            out_src_q   <= out_src_d;
`ifdef C_BURST_SCHED_TIMEOUT_EN
            stall_q     <= stall_d;
            abort_q     <= abort_d;
`endif
        end
    end

    // Accept pulse is combinational, so mask it while reset is held.
    assign req_ready = rst ? '0 : req_ready_c;
    assign out_valid = out_valid_q;
    assign out_d     = out_d_q;
    assign out_idx   = beat_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign c_state   = state_q;
`ifdef C_BURST_SCHED_TIMEOUT_EN
    assign abort     = abort_q;
`else
    assign abort     = 1'b0;
`endif

endmodule

// File: tb/tb_c_burst_scheduler.sv
// Directed bench for c_burst_scheduler: default build plus a BURST_LEN=1 instance.
module tb_c_burst_scheduler;
    import c_burst_scheduler_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [11:0] req_d;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    dSt          out_d;
    logic [3:0]  out_idx;
    logic        out_last;
    logic [1:0]  out_src;
    cStateT      c_state;
    logic        abort;

    logic [3:0]  req_valid1;
    logic [11:0] req_d1;
    logic [3:0]  req_ready1;
    logic        out_valid1;
    logic        out_ready1;
    dSt          out_d1;
    logic [3:0]  out_idx1;
    logic        out_last1;
    logic [1:0]  out_src1;
    cStateT      c_state1;
    logic        abort1;

    int tests;
    int fails;

    c_burst_scheduler #(.NUM_REQ(4), .BURST_LEN(10)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_d(req_d), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_idx(out_idx),
        .out_last(out_last), .out_src(out_src), .c_state(c_state), .abort(abort)
    );

    c_burst_scheduler #(.NUM_REQ(4), .BURST_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_d(req_d1), .req_ready(req_ready1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_d(out_d1), .out_idx(out_idx1),
        .out_last(out_last1), .out_src(out_src1), .c_state(c_state1), .abort(abort1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_d = '0; out_ready = 1'b1;
        req_valid1 = '0; req_d1 = '0; out_ready1 = 1'b1;
        tick(); tick();
        tests++;
        if ({c_state, out_valid, out_last, out_idx, out_d.d, out_src, req_ready, abort} !== 18'h0) begin
            fails++;
            $display("FAIL reset_state: got %h required 0",
                     {c_state, out_valid, out_last, out_idx, out_d.d, out_src, req_ready, abort});
        end
        rst = 1'b0;
        tick();
        tests++;
        if ({c_state, req_ready, out_valid} !== 9'h0) begin
            fails++;
            $display("FAIL idle_no_request: got %h required 0", {c_state, req_ready, out_valid});
        end
        $display("[TB] reset: done");
    endtask

    task automatic test_single();
        logic [2:0] exp_d [10] = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        req_d = '0; req_d[8:6] = 3'd5; req_valid = 4'b0100; out_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL single_accept: got %b required 0100", req_ready);
        end
        tick();
        req_valid = '0;
        for (int i = 0; i < 10; i++) begin
            tests++;
            if ({out_valid, out_src, out_idx, out_d.d, out_last, req_ready} !==
                {1'b1, 2'd2, 4'(i), exp_d[i], (i == 9), 4'b0000}) begin
                fails++;
                $display("FAIL single_beat%0d: got v/src/idx/d/last/rdy=%h required %h", i,
                         {out_valid, out_src, out_idx, out_d.d, out_last, req_ready},
                         {1'b1, 2'd2, 4'(i), exp_d[i], (i == 9), 4'b0000});
            end
            tick();
        end
        tests++;
        if ({c_state, out_valid} !== 5'h0) begin
            fails++;
            $display("FAIL single_return_idle: got state/valid=%h required 0", {c_state, out_valid});
        end
        $display("[TB] single: burst of 10 from requester 2 checked");
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        rst = 1'b1; tick(); rst = 1'b0;
        req_d = {3'd4, 3'd3, 3'd2, 3'd1};
        req_valid = 4'b1111; out_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if ({c_state, out_valid, req_ready} !== {4'h0, 1'b0, 4'(1 << order[k])}) begin
                fails++;
                $display("FAIL rr_grant%0d: got state/valid/rdy=%h required %h", k,
                         {c_state, out_valid, req_ready}, {4'h0, 1'b0, 4'(1 << order[k])});
            end
            tick();
            tests++;
            if ({out_valid, out_src, out_idx, out_d.d} !== {1'b1, 2'(order[k]), 4'd0, 3'(order[k] + 1)}) begin
                fails++;
                $display("FAIL rr_first_beat%0d: got %h required %h", k,
                         {out_valid, out_src, out_idx, out_d.d},
                         {1'b1, 2'(order[k]), 4'd0, 3'(order[k] + 1)});
            end
            repeat (10) tick();
            $display("[TB] round_robin: burst %0d to requester %0d", k, order[k]);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        int n;
        req_d = '0; req_d[5:3] = 3'd3; req_valid = 4'b0010; out_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL bp_accept: got %b required 0010", req_ready);
        end
        tick();
        req_valid = '0;
        n = 0;
        for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
            out_ready = (cyc % 3 == 0);
            tests++;
            if ({out_valid, out_idx, out_d.d, out_last} !== {1'b1, 4'(n), 3'(3 + n), (n == 9)}) begin
                fails++;
                $display("FAIL bp_cycle%0d: got v/idx/d/last=%h required %h", cyc,
                         {out_valid, out_idx, out_d.d, out_last}, {1'b1, 4'(n), 3'(3 + n), (n == 9)});
            end
            if (out_ready) n++;
            tick();
        end
        out_ready = 1'b1;
        tests++;
        if ({n[3:0], c_state, out_valid} !== {4'd10, 4'h0, 1'b0}) begin
            fails++;
            $display("FAIL bp_total: got transfers/state/valid=%h required %h",
                     {n[3:0], c_state, out_valid}, {4'd10, 4'h0, 1'b0});
        end
        $display("[TB] backpressure: %0d transfers", n);
    endtask

    task automatic test_reset_mid_burst();
        req_d = '0; req_d[8:6] = 3'd2; req_valid = 4'b0100; out_ready = 1'b1;
        tick();
        req_valid = '0;
        repeat (4) tick();
        tests++;
        if ({out_valid, out_idx} !== {1'b1, 4'd4}) begin
            fails++;
            $display("FAIL mid_at_beat4: got %h required %h", {out_valid, out_idx}, {1'b1, 4'd4});
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({out_valid, c_state, out_idx} !== 9'h0) begin
            fails++;
            $display("FAIL mid_async_reset: got %h required 0", {out_valid, c_state, out_idx});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req_d = {3'd6, 3'd0, 3'd0, 3'd1}; req_valid = 4'b1001;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL mid_regrant: got %b required 0001", req_ready);
        end
        tick();
        req_valid = '0;
        tests++;
        if ({out_valid, out_src, out_d.d} !== {1'b1, 2'd0, 3'd1}) begin
            fails++;
            $display("FAIL mid_new_burst: got %h required %h", {out_valid, out_src, out_d.d}, {1'b1, 2'd0, 3'd1});
        end
        repeat (10) tick();
        $display("[TB] reset_mid_burst: requester 0 granted after reset");
    endtask

    task automatic test_burst_len1();
        req_d1 = '0; req_d1[2:0] = 3'd7; req_valid1 = 4'b0001; out_ready1 = 1'b1;
        #1;
        tests++;
        if (req_ready1 !== 4'b0001) begin
            fails++;
            $display("FAIL len1_accept: got %b required 0001", req_ready1);
        end
        tick();
        req_valid1 = '0;
        tests++;
        if ({out_valid1, out_d1.d, out_idx1, out_last1} !== {1'b1, 3'd7, 4'd0, 1'b1}) begin
            fails++;
            $display("FAIL len1_beat: got %h required %h", {out_valid1, out_d1.d, out_idx1, out_last1},
                     {1'b1, 3'd7, 4'd0, 1'b1});
        end
        tick();
        tests++;
        if ({out_valid1, c_state1} !== 5'h0) begin
            fails++;
            $display("FAIL len1_idle: got %h required 0", {out_valid1, c_state1});
        end
        $display("[TB] burst_len1: single beat checked");
    endtask

`ifdef C_BURST_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        req_d = {3'd0, 3'd4, 3'd2, 3'd0}; req_valid = 4'b0010; out_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL to_accept: got %b required 0010", req_ready);
        end
        tick();
        req_valid = 4'b0101;
        tick(); tick();
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tests++;
            if ({c_state, abort, out_idx} !== {4'h1, 1'b0, 4'd2}) begin
                fails++;
                $display("FAIL to_stall%0d: got %h required %h", k, {c_state, abort, out_idx}, {4'h1, 1'b0, 4'd2});
            end
            tick();
        end
        tests++;
        if ({c_state, abort, out_valid} !== {4'h2, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL to_abort: got %h required %h", {c_state, abort, out_valid}, {4'h2, 1'b1, 1'b0});
        end
        tick();
        tests++;
        if ({c_state, abort, req_ready} !== {4'h0, 1'b0, 4'b0100}) begin
            fails++;
            $display("FAIL to_rearb: got %h required %h", {c_state, abort, req_ready}, {4'h0, 1'b0, 4'b0100});
        end
        tick();
        req_valid = '0; out_ready = 1'b1;
        tests++;
        if ({out_src, out_d.d} !== {2'd2, 3'd4}) begin
            fails++;
            $display("FAIL to_next_burst: got %h required %h", {out_src, out_d.d}, {2'd2, 3'd4});
        end
        repeat (10) tick();
        $display("[TB] timeout: abort and re-arbitration checked");
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid_burst();
        test_burst_len1();
`ifdef C_BURST_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/c_burst_scheduler.md
Name: c_burst_scheduler

Overview:
- Round-robin scheduler that shares blockC's d-datapath among NUM_REQ requesters.
- Each request carries one dSt seed. On a grant, the block runs a BURST_LEN-beat burst to blockC with a valid/ready handshake.
- It exports its cStateT state so blockC and debug logic can observe sequencing.
- It sits between the requester agents and blockC's input port.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- BURST_LEN, C_ANOTHER_SIZE (10): beats per burst; legal range 1..15.
- TIMEOUT, 16: cycles out_ready may stay low mid-burst before abort. Used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_d  in  NUM_REQ*D_SIZE  per-requester dT seed; requester i occupies bits [i*D_SIZE +: D_SIZE].
- req_ready  out  NUM_REQ  one-hot accept pulse.
- out_valid  out  1  beat valid to blockC.
- out_ready  in  1  blockC accepts beat.
- out_d  out  dSt  beat payload.
- out_idx  out  4  beat index, 0..BURST_LEN-1.
- out_last  out  1  final beat of burst.
- out_src  out  $clog2(NUM_REQ)  index of granted requester.
- c_state  out  cStateT  current FSM state.
- abort  out  1  one-cycle pulse when a burst is aborted; tied 0 without the optional feature.

Behaviour:
- Reset values (async, rst=1): state IDLE, c_state=4'h0, out_valid=0, out_last=0, out_idx=0, out_d=0, out_src=0, req_ready=0, abort=0, rr_ptr=NUM_REQ-1 (requester 0 wins first), beat=0, captured seed=0.
- State encodings: IDLE=4'h0, BURST=4'h1, ABORT=4'h2. All other codes are unused; an unused code returns to IDLE on the next clock.
- Arbitration in IDLE:
  - If any req_valid is high, the winner is the first set bit scanning from rr_ptr+1 upward, wrapping at NUM_REQ.
  - req_ready[winner] is asserted combinationally in that cycle. This is the only cycle req_ready can be high.
  - On the clock edge: capture the seed from req_d[winner], set out_src=winner, rr_ptr=winner, beat=0, next state BURST.
  - With no req_valid set, the block stays in IDLE and all req_ready bits are 0.
- BURST:
  - out_valid=1.
  - out_idx=beat.
  - out_d.d = (seed + beat[D_SIZE-1:0]) mod 2^D_SIZE; wrap is silent.
  - out_last = (beat == BURST_LEN-1).
  - out_d, out_idx and out_last are registered/stable while out_valid=1 && out_ready=0.
- Beat handshake: a beat transfers when out_valid && out_ready. beat increments; on a transfer with out_last=1, next state is IDLE.
- Latency:
  - First beat out_valid rises the cycle after the accept.
  - Between bursts there is exactly one IDLE cycle, so at least one bubble separates back-to-back bursts.
  - Minimum burst duration is BURST_LEN cycles.
- req_valid changes during BURST are ignored; requesters must hold req_valid until they see req_ready.
- Fairness: a requester that holds req_valid is granted within NUM_REQ-1 bursts.
- BURST_LEN=1: first beat has out_last=1 and out_idx=0.
- Reset asserted mid-burst: outputs drop to reset values immediately. The partial burst is lost and blockC must discard it; no completion is reported.

Optional Feature:
- Macro: C_BURST_SCHED_TIMEOUT_EN.
- Enabled:
  - A stall counter counts consecutive BURST cycles with out_ready=0 and clears on any transfer.
  - When the count reaches TIMEOUT, next state is ABORT.
  - ABORT lasts one cycle: out_valid=0, abort=1, c_state=4'h2. Next state is IDLE; rr_ptr keeps the aborted winner.
  - A transfer in the same cycle the counter would reach TIMEOUT has priority; no abort.
- Disabled: no counter and no ABORT state are built; abort is tied 0; a burst waits indefinitely.

Decomposition:
- The package holds C_ANOTHER_SIZE, D_SIZE, cStateT, dT and dSt.
- Add to the package: state localparams C_ST_IDLE=4'h0, C_ST_BURST=4'h1, C_ST_ABORT=4'h2.
- Sub-module: c_rr_arbiter, a combinational rotate-priority-rotate-back winner select. Inputs: req vector and rr_ptr. Outputs: one-hot grant and encoded index.

Test Plan:
- Single request: reset, req_valid=4'b0100 with seed 5 -> req_ready=4'b0100 for one cycle. Ten beats follow with out_src=2, out_d.d=5,6,7,0,1,2,3,4,5,6 and out_idx 0..9; out_last is high only on idx 9; state returns to IDLE.
- Round-robin: all four requests held continuously -> grant order 0,1,2,3,0, with exactly one IDLE cycle between bursts.
- Backpressure: out_ready toggled 1,0,0,1,... -> payload stable during stalls, no beat duplicated or dropped, total 10 transfers.
- Reset mid-burst: rst asserted at beat 4 -> out_valid=0 and c_state=0 asynchronously. After release, a new request from requester 3 with requester 0 also pending -> requester 0 is granted first.
- BURST_LEN=1 build: seed 7 -> one beat, out_d.d=7, out_idx=0, out_last=1.
- With C_BURST_SCHED_TIMEOUT_EN: out_ready held 0 for 16 cycles at beat 2 -> abort pulses once and c_state=4'h2 for one cycle, then IDLE. A pending request is re-arbitrated starting after the aborted requester.
